pe_array_feeder: RTL and testbench



---
 rtl/pe_array_feeder.sv | 213 +++++++++++++++++++++
 tb/tb_pe_array_feeder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_feeder.sv
// pe_array_feeder
//   Transmit-side front end for a 4x4 systolic PE array. Each accepted beat
//   carries one K-step: four data words (one per array row) and four weight
//   words (one per array column). The words are launched into the array with
//   a diagonal skew: lane i is delayed by 1+i registers. Cycles without an
//   accepted beat inject zeros on every lane, so alignment is preserved and
//   nothing is added to the MACs. After the last beat the feeder keeps
//   injecting zeros for FLUSH_CYCLES cycles so the array can finish
//   accumulating. It then pulses done for one cycle.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   start, cfg_mode      begin a tile (sampled in IDLE only), array mode
//   in_valid/in_ready    beat handshake
//   in_data, in_weight   4 lanes of DW bits; lane i at [i*DW +: DW]
//   in_last              marks the final beat of the tile
//   dataN_out, weightN_out  skewed lane outputs to the array
//   mode_out             array mode, held from start through DONE
//   busy, done           tile in progress / one-cycle end-of-tile pulse
//   beat_cnt             beats accepted in the current or last tile
//   stall_cnt            STREAM cycles without a beat (optional counter)
//
// Build option
//   PE_FEED_PERF_EN      when defined, stall_cnt is a live saturating counter;
//                        when undefined, stall_cnt is tied to zero.

module pe_array_feeder #(
  parameter int DW           = 32,
  parameter int FLUSH_CYCLES = 10,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cfg_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*DW-1:0]   in_data,
  input  logic [4*DW-1:0]   in_weight,
  input  logic              in_last,
  output logic [DW-1:0]     data0_out,
  output logic [DW-1:0]     data1_out,
  output logic [DW-1:0]     data2_out,
  output logic [DW-1:0]     data3_out,
  output logic [DW-1:0]     weight0_out,
  output logic [DW-1:0]     weight1_out,
  output logic [DW-1:0]     weight2_out,
  output logic [DW-1:0]     weight3_out,
  output logic [1:0]        mode_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Flush counter only needs to hold FLUSH_CYCLES-1.
  localparam int FCW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [FCW-1:0]   flush_cnt;
  logic             accept;
  logic             start_acc;

  logic [DW-1:0]    feed_d [4];
  logic [DW-1:0]    feed_w [4];

  logic [DW-1:0]    data_p0   [4];
  logic [DW-1:0]    data_p1   [1:3];
  logic [DW-1:0]    data_p2   [2:3];
  logic [DW-1:0]    data_p3;
  logic [DW-1:0]    weight_p0 [4];
  logic [DW-1:0]    weight_p1 [1:3];
  logic [DW-1:0]    weight_p2 [2:3];
  logic [DW-1:0]    weight_p3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign accept    = in_valid & in_ready;
  assign start_acc = (state_q == ST_IDLE) & start;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && in_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (flush_cnt == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      flush_cnt <= '0;
      mode_out  <= '0;
      beat_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        mode_out <= cfg_mode;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= sat_inc(beat_cnt);
      end
      if (accept && in_last) begin
        flush_cnt <= FCW'(FLUSH_CYCLES - 1);
      end else if (state_q == ST_FLUSH && flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 1'b1;
      end
    end
  end

`ifdef PE_FEED_PERF_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (state_q == ST_STREAM && !in_valid) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  // Anything not accepted enters the skew line as zero, so bubbles, flush
  // and idle cycles all feed 0 into every MAC while keeping lanes aligned.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      feed_d[r] = accept ? in_data[r*DW +: DW]   : '0;
      feed_w[r] = accept ? in_weight[r*DW +: DW] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) begin
        data_p0[r]   <= '0;
        weight_p0[r] <= '0;
      end
      for (int r = 1; r < 4; r++) begin
        data_p1[r]   <= '0;
        weight_p1[r] <= '0;
      end
      for (int r = 2; r < 4; r++) begin
        data_p2[r]   <= '0;
        weight_p2[r] <= '0;
      end
      data_p3   <= '0;
      weight_p3 <= '0;
    end else begin
      // p0: every lane registers its feed word
      for (int r = 0; r < 4; r++) begin
        data_p0[r]   <= feed_d[r];
        weight_p0[r] <= feed_w[r];
      end
      // p1: lanes 1..3
      for (int r = 1; r < 4; r++) begin
        data_p1[r]   <= data_p0[r];
        weight_p1[r] <= weight_p0[r];
      end
      // p2: lanes 2..3
      for (int r = 2; r < 4; r++) begin
        data_p2[r]   <= data_p1[r];
        weight_p2[r] <= weight_p1[r];
      end
      // p3: lane 3
      data_p3   <= data_p2[3];
      weight_p3 <= weight_p2[3];
    end
  end

  assign data0_out   = data_p0[0];
  assign data1_out   = data_p1[1];
  assign data2_out   = data_p2[2];
  assign data3_out   = data_p3;
  assign weight0_out = weight_p0[0];
  assign weight1_out = weight_p1[1];
  assign weight2_out = weight_p2[2];
  assign weight3_out = weight_p3;

endmodule

// File: tb/tb_pe_array_feeder.sv
// Testbench for pe_array_feeder: scoreboard of skewed lane words and done
// pulses, plus point checks of handshake, mode and counters.

module tb_pe_array_feeder;

  localparam int DW = 32;
  localparam int FC = 10;
  localparam int CW = 16;

`ifdef PE_FEED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [1:0]      cfg_mode;
  logic            in_valid;
  logic            in_ready;
  logic [4*DW-1:0] in_data;
  logic [4*DW-1:0] in_weight;
  logic            in_last;
  logic [DW-1:0]   d0, d1, d2, d3, w0, w1, w2, w3;
  logic [1:0]      mode_out;
  logic            busy;
  logic            done;
  logic [CW-1:0]   beat_cnt;
  logic [CW-1:0]   stall_cnt;

  pe_array_feeder #(.DW(DW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_weight(in_weight), .in_last(in_last),
    .data0_out(d0), .data1_out(d1), .data2_out(d2), .data3_out(d3),
    .weight0_out(w0), .weight1_out(w1), .weight2_out(w2), .weight3_out(w3),
    .mode_out(mode_out), .busy(busy), .done(done),
    .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int            cyc;
    logic          is_w;
    logic [1:0]    lane;
    logic [DW-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  int   checks = 0;
  int   fails  = 0;
  bit   mon_en = 1'b0;

  int         model_bc;
  int         model_stall;
  logic [1:0] model_mode;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [4*DW-1:0] pack4(input logic [DW-1:0] base, input logic [DW-1:0] inc);
    logic [4*DW-1:0] v;
    for (int r = 0; r < 4; r++) v[r*DW +: DW] = base + DW'(r) * inc;
    return v;
  endfunction

  // Lane scoreboard: every cycle, each lane must show its queued word or 0.
  logic [DW-1:0] ed [4];
  logic [DW-1:0] ew [4];
  logic [DW-1:0] ad [4];
  logic [DW-1:0] aw [4];
  logic          exp_done;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        ed[i] = '0;
        ew[i] = '0;
      end
      for (int j = exp_q.size() - 1; j >= 0; j--) begin
        if (exp_q[j].cyc == cyc) begin
          if (exp_q[j].is_w) ew[exp_q[j].lane] = exp_q[j].val;
          else               ed[exp_q[j].lane] = exp_q[j].val;
          exp_q.delete(j);
        end
      end
      ad = '{d0, d1, d2, d3};
      aw = '{w0, w1, w2, w3};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("data%0d_out", i), ad[i], ed[i]);
        chk($sformatf("weight%0d_out", i), aw[i], ew[i]);
      end
      exp_done = 1'b0;
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        exp_done = 1'b1;
        void'(done_q.pop_front());
      end
      chk("done", done, exp_done);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_weight = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic do_start(input logic [1:0] mode);
    start    = 1'b1;
    cfg_mode = mode;
    next();
    start       = 1'b0;
    cfg_mode    = 2'($urandom());
    model_mode  = mode;
    model_bc    = 0;
    model_stall = 0;
  endtask

  task automatic drive_beat(input logic [4*DW-1:0] d, input logic [4*DW-1:0] w, input logic last);
    in_valid  = 1'b1;
    in_data   = d;
    in_weight = w;
    in_last   = last;
    @(negedge clk);
    chk("in_ready", in_ready, 1'b1);
    chk("busy", busy, 1'b1);
    chk("mode_out", mode_out, model_mode);
    chk("beat_cnt", beat_cnt, CW'(model_bc));
    chk("stall_cnt", stall_cnt, CW'(model_stall));
    model_bc++;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{cyc: cyc + 1 + i, is_w: 1'b0, lane: 2'(i), val: d[i*DW +: DW]});
      exp_q.push_back('{cyc: cyc + 1 + i, is_w: 1'b1, lane: 2'(i), val: w[i*DW +: DW]});
    end
    if (last) done_q.push_back(cyc + FC + 1);
    next();
    in_valid = 1'b0;
    in_last  = 1'b0;
    junk();
  endtask

  task automatic drive_bubble();
    in_valid = 1'b0;
    junk();
    @(negedge clk);
    chk("bubble_ready", in_ready, 1'b1);
    chk("stall_cnt", stall_cnt, CW'(model_stall));
    if (PERF) model_stall++;
    next();
  endtask

  // Returns at the falling edge of the done cycle.
  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else next();
    end
    if (!seen) chk("done_timeout", 1'b0, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("ready_at_done", in_ready, 1'b0);
    chk("beat_cnt_end", beat_cnt, CW'(model_bc));
    chk("mode_end", mode_out, model_mode);
    chk("stall_end", stall_cnt, CW'(model_stall));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_mode = 2'b00;
    in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; in_weight = '0;
    model_bc = 0; model_stall = 0; model_mode = 2'b00;
    next();
    next();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mode", mode_out, 2'b00);
    chk("rst_beat_cnt", beat_cnt, '0);
    chk("rst_stall_cnt", stall_cnt, '0);
    next();

    // Tile 1: four stall-free beats, ignored start in STREAM and FLUSH.
    do_start(2'b01);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        start    = 1'b1;
        cfg_mode = 2'b11;
      end
      drive_beat(pack4(DW'(32'h10 * k), 1), pack4(DW'(32'h20 * k), 1), k == 3);
      start = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      next();
      start    = 1'b1;
      cfg_mode = 2'b11;
      @(negedge clk);
      chk("flush_ready", in_ready, 1'b0);
      chk("flush_busy", busy, 1'b1);
      chk("flush_mode", mode_out, model_mode);
    end
    next();
    start = 1'b0;
    wait_done(30);

    // Tile 2: start right after done, three beats.
    next();
    do_start(2'b10);
    for (int k = 0; k < 3; k++)
      drive_beat(pack4(DW'(32'hA00 + 32'h10 * k), 1), pack4(DW'(32'hB00 + 32'h10 * k), 1), k == 2);
    wait_done(30);
    next();

    // Bubble tile.
    do_start(2'b00);
    drive_beat(pack4(DW'(32'h300), 1), pack4(DW'(32'h400), 1), 1'b0);
    drive_bubble();
    drive_beat(pack4(DW'(32'h320), 1), pack4(DW'(32'h420), 1), 1'b1);
    wait_done(30);
    next();

    // One-beat tile.
    do_start(2'b10);
    drive_beat(pack4(DW'(1), 0), pack4(DW'(1), 0), 1'b1);
    wait_done(30);
    next();
    @(negedge clk);
    chk("busy_idle", busy, 1'b0);
    next();

    // Reset two cycles into FLUSH: in-flight words and done are discarded.
    do_start(2'b11);
    drive_beat(pack4(DW'(32'h500), 1), pack4(DW'(32'h600), 1), 1'b0);
    drive_beat(pack4(DW'(32'h510), 1), pack4(DW'(32'h610), 1), 1'b1);
    next();
    rst_n = 1'b0;
    for (int j = exp_q.size() - 1; j >= 0; j--)
      if (exp_q[j].cyc > cyc) exp_q.delete(j);
    for (int j = done_q.size() - 1; j >= 0; j--)
      if (done_q[j] > cyc) done_q.delete(j);
    next();
    rst_n = 1'b1;
    model_mode = 2'b00; model_bc = 0; model_stall = 0;
    @(negedge clk);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_ready", in_ready, 1'b0);
    chk("mrst_mode", mode_out, 2'b00);
    chk("mrst_beat_cnt", beat_cnt, '0);
    chk("mrst_stall_cnt", stall_cnt, '0);
    next();
    in_valid = 1'b1;
    in_last  = 1'b1;
    junk();
    @(negedge clk);
    chk("idle_ready", in_ready, 1'b0);
    next();
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 15; i++) next();
    @(negedge clk);
    chk("idle_beat_cnt", beat_cnt, '0);
    chk("sb_drain", 64'(exp_q.size() + done_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
